// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - Shared types and constants for the program loader
package imem_program_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } ld_state_e;

  localparam logic [7:0] NOP_INSTR  = 8'h00;
  localparam int         DEF_DEPTH  = 64;
  localparam int         DEF_ADDR_W = 8;

endpackage

// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - Loader byte stream, fetch port and core-control bundle
interface imem_program_loader_if
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic [ADDR_W-1:0] fetch_addr;
  logic [7:0]        fetch_instr;
  logic              cpu_reset_n;
  logic              load_done;
  logic              load_err;

  modport master (
    output ld_valid, ld_data, ld_last, fetch_addr,
    input  ld_ready, fetch_instr, cpu_reset_n, load_done, load_err
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, fetch_addr,
    output ld_ready, fetch_instr, cpu_reset_n, load_done, load_err
  );
endinterface

// File: rtl/imem_program_loader_imem_array.sv
// rtl/imem_program_loader_imem_array.sv - 8-bit instruction storage, sync write, async read
module imem_array
  import imem_program_loader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - Streams a program image into instruction memory; IMEM_CHECKSUM_EN adds a trailing checksum byte
// Holds the core in reset while loading and gates fetches to the loaded range.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                  clk,
  input logic                  reset,
  imem_program_loader_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // loaded_len caps at DEPTH, or at the largest ADDR_W value when DEPTH does not fit
  localparam int                LEN_CAP  = (DEPTH < (1 << ADDR_W)) ? DEPTH : (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(LEN_CAP);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              accept, we, csum_byte, at_end;
  logic [7:0]        rdata;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign accept = bus.ld_valid & (state_q == LOAD);
`ifdef IMEM_CHECKSUM_EN
  assign csum_byte = accept & bus.ld_last;
`else
  assign csum_byte = 1'b0;
`endif
  assign we     = accept & ~csum_byte;
  assign at_end = (wr_ptr_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
`ifdef IMEM_CHECKSUM_EN
      // Empty image (checksum only) is rejected even if the sum would match
      if (bus.ld_last) begin
        state_d = ((len_q != '0) && (sum_q == bus.ld_data)) ? RUN : ERR;
      end else if (at_end) begin
        state_d = ERR;
      end
`else
      if (bus.ld_last) begin
        state_d = RUN;
      end else if (at_end) begin
        state_d = ERR;
      end
`endif
    end
  end

  always_comb begin
    bus.ld_ready    = 1'b0;
    bus.cpu_reset_n = 1'b0;
    bus.load_done   = 1'b0;
    bus.load_err    = 1'b0;
    unique case (state_q)
      LOAD: bus.ld_ready = 1'b1;
      RUN: begin
        bus.cpu_reset_n = 1'b1;
        bus.load_done   = 1'b1;
      end
      ERR:     bus.load_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    if (we) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (len_q != LEN_MAX) begin
        len_d = len_q + ADDR_W'(1);
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  assign sum_d = we ? (sum_q + bus.ld_data) : sum_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      len_q    <= '0;
`ifdef IMEM_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q[IDX_W-1:0]),
    .wdata (bus.ld_data),
    .raddr (bus.fetch_addr[IDX_W-1:0]),
    .rdata (rdata)
  );

  // len_q resets to zero, so stale or unwritten storage never reaches the core
  assign bus.fetch_instr = ((state_q == RUN) && (bus.fetch_addr < len_q)) ? rdata : NOP_INSTR;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - Directed bench with an image-level reference model
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_program_loader_if #(.ADDR_W(8)) bus0 ();
  imem_program_loader_if #(.ADDR_W(8)) bus1 ();

  imem_program_loader #(.DEPTH(64), .ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus0));
  imem_program_loader #(.DEPTH(4),  .ADDR_W(8)) dut4 (.clk(clk), .reset(reset), .bus(bus1));

  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_en = 0;
  int         dep [2] = '{64, 4};
  logic [7:0] m_img [2][256];
  int         m_len [2];
  bit         m_done [2];
  bit         m_err [2];
  logic [7:0] m_sum [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 0; m_done[k] = 0; m_err[k] = 0; m_sum[k] = 8'h00;
    end
  endtask

  // Image-level rules: bytes append to the image; last finishes it, a full image without last fails
  task automatic model_accept(int k, logic [7:0] d, logic last);
`ifdef IMEM_CHECKSUM_EN
    if (last) begin
      if (m_len[k] > 0 && m_sum[k] == d) m_done[k] = 1; else m_err[k] = 1;
    end else begin
      m_img[k][m_len[k]] = d;
      m_len[k]++;
      m_sum[k] = m_sum[k] + d;
      if (m_len[k] == dep[k]) m_err[k] = 1;
    end
`else
    m_img[k][m_len[k]] = d;
    m_len[k]++;
    if (last) m_done[k] = 1;
    else if (m_len[k] == dep[k]) m_err[k] = 1;
`endif
  endtask

  function automatic logic [7:0] exp_fetch(int k, int addr);
    if (m_done[k] && addr < m_len[k]) return m_img[k][addr];
    return 8'h00;
  endfunction

  function automatic logic [7:0] get_fetch(int k);
    return (k == 0) ? bus0.fetch_instr : bus1.fetch_instr;
  endfunction

  task automatic set_addr(int k, int a);
    if (k == 0) bus0.fetch_addr = 8'(a); else bus1.fetch_addr = 8'(a);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      bus0.ld_data = 8'($urandom_range(0, 255));
      bus0.ld_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus0.ld_last = 1'b0;
  endtask

  task automatic send(int k, logic [7:0] d, logic last);
    if (k == 0) begin
      bus0.ld_valid = 1'b1; bus0.ld_data = d; bus0.ld_last = last;
    end else begin
      bus1.ld_valid = 1'b1; bus1.ld_data = d; bus1.ld_last = last;
    end
    @(posedge clk);
    if (!m_done[k] && !m_err[k]) model_accept(k, d, last);
    #1;
    bus0.ld_valid = 1'b0; bus0.ld_last = 1'b0;
    bus1.ld_valid = 1'b0; bus1.ld_last = 1'b0;
  endtask

  task automatic send_image(int k, input logic [7:0] img [$], bit gaps);
`ifdef IMEM_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    foreach (img[i]) begin
      send(k, img[i], 1'b0);
      s = s + img[i];
      if (gaps) idle($urandom_range(0, 2));
    end
    send(k, s, 1'b1);
`else
    foreach (img[i]) begin
      send(k, img[i], (i == img.size() - 1));
      if (gaps && i != img.size() - 1) idle($urandom_range(0, 2));
    end
`endif
  endtask

  task automatic readback(int k, string tag, input logic [7:0] exp [$]);
    for (int a = 0; a <= exp.size(); a++) begin
      set_addr(k, a);
      #1;
      chk($sformatf("%s_addr%0d", tag, a), get_fetch(k), (a < exp.size()) ? exp[a] : 8'h00);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] img1 [$];
    logic [7:0] img4 [$];
    logic [7:0] zeros4 [$];
    img1   = '{8'h19, 8'h49, 8'h0B, 8'hC5, 8'h4B, 8'h19};
    img4   = '{8'hA1, 8'hB2};
    zeros4 = '{8'h00, 8'h00, 8'h00, 8'h00};
    bus0.ld_valid = 0; bus0.ld_data = 0; bus0.ld_last = 0; bus0.fetch_addr = 0;
    bus1.ld_valid = 0; bus1.ld_data = 0; bus1.ld_last = 0; bus1.fetch_addr = 0;
    model_clear();
    #1;
    do_reset();
    chk_en = 1;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("cyc_ready0", bus0.ld_ready, !m_done[0] && !m_err[0]);
          chk("cyc_cpurst0", bus0.cpu_reset_n, m_done[0]);
          chk("cyc_done0", bus0.load_done, m_done[0]);
          chk("cyc_err0", bus0.load_err, m_err[0]);
          chk("cyc_fetch0", bus0.fetch_instr, exp_fetch(0, bus0.fetch_addr));
          chk("cyc_ready1", bus1.ld_ready, !m_done[1] && !m_err[1]);
          chk("cyc_err1", bus1.load_err, m_err[1]);
          chk("cyc_fetch1", bus1.fetch_instr, exp_fetch(1, bus1.fetch_addr));
        end
      end
    join_none

    chk("rst_ready", bus0.ld_ready, 1);
    chk("rst_done", bus0.load_done, 0);
    chk("rst_cpurst", bus0.cpu_reset_n, 0);
    chk("rst_err", bus0.load_err, 0);
    chk("rst_fetch", bus0.fetch_instr, 8'h00);

    // Scenario 1: plain image, release one cycle after the last accept
    send_image(0, img1, 1'b0);
    chk("s1_done", bus0.load_done, 1);
    chk("s1_cpurst", bus0.cpu_reset_n, 1);
    chk("s1_err", bus0.load_err, 0);
    chk("s1_ready", bus0.ld_ready, 0);
    readback(0, "s1", img1);
    send(0, 8'hEE, 1'b1);
    send(0, 8'hEF, 1'b0);
    readback(0, "s1_ignored", img1);

    // Scenario 2: gapped valid with junk data between bytes
    do_reset();
    chk("s2_busy", bus0.load_done, 0);
    send_image(0, img1, 1'b1);
    idle(1);
    chk("s2_done", bus0.load_done, 1);
    readback(0, "s2", img1);

    // Scenario 3: DEPTH=4 overflow
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b0);
    send(1, 8'h33, 1'b0);
    chk("s3_not_yet", bus1.load_err, 0);
    send(1, 8'h44, 1'b0);
    chk("s3_err", bus1.load_err, 1);
    chk("s3_ready", bus1.ld_ready, 0);
    chk("s3_cpurst", bus1.cpu_reset_n, 0);
    chk("s3_done", bus1.load_done, 0);
    send(1, 8'h55, 1'b1);
    chk("s3_sticky", bus1.load_err, 1);
    readback(1, "s3", zeros4);

    // Scenario 4/5: reset mid-load then short image, fetch gated during LOAD
    do_reset();
    send(0, 8'hC1, 1'b0);
    send(0, 8'hD2, 1'b0);
    send(0, 8'hE3, 1'b0);
    do_reset();
    send(0, 8'hA1, 1'b0);
    set_addr(0, 0);
    #1;
    chk("s5_fetch_in_load", bus0.fetch_instr, 8'h00);
`ifdef IMEM_CHECKSUM_EN
    send(0, 8'hB2, 1'b0);
    send(0, 8'h53, 1'b1);
`else
    send(0, 8'hB2, 1'b1);
`endif
    chk("s4_done", bus0.load_done, 1);
    readback(0, "s4", img4);

    // Exact-fit image in the DEPTH=4 instance
    do_reset();
    send(1, 8'h05, 1'b0);
    send(1, 8'h06, 1'b0);
    send(1, 8'h07, 1'b0);
    send(1, 8'h08, 1'b1);
`ifndef IMEM_CHECKSUM_EN
    chk("fit_done", bus1.load_done, 1);
    set_addr(1, 3);
    #1;
    chk("fit_addr3", bus1.fetch_instr, 8'h08);
`endif
    idle(1);

    // Scenario 6: checksum good / bad (plain build treats last byte as code)
    do_reset();
    send(0, 8'h10, 1'b0);
    send(0, 8'h20, 1'b0);
    send(0, 8'h30, 1'b1);
    chk("s6_done", bus0.load_done, 1);
    set_addr(0, 2);
    #1;
`ifdef IMEM_CHECKSUM_EN
    chk("s6_len2", bus0.fetch_instr, 8'h00);
`else
    chk("s6_addr2", bus0.fetch_instr, 8'h30);
`endif
    idle(1);
    do_reset();
    send(0, 8'h10, 1'b0);
    send(0, 8'h20, 1'b0);
    send(0, 8'h31, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    chk("s6_bad_err", bus0.load_err, 1);
    chk("s6_bad_done", bus0.load_done, 0);
    do_reset();
    send(0, 8'h00, 1'b1);
    chk("s6_empty_err", bus0.load_err, 1);
`else
    chk("s6_bad_done", bus0.load_done, 1);
    set_addr(0, 2);
    #1;
    chk("s6_bad_addr2", bus0.fetch_instr, 8'h31);
`endif
    idle(2);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
